slice_seq_ctrl: RTL and testbench
=================================

// Module: slice_seq_ctrl
// PURPOSE
//  Time-multiplexes one 12-bit slice datapath (submodule1-class A/B->C cell) across a
//  NUM_SLICES*SLICE_W operand word, replacing per-slice replication. Accepts a word pair
//  via valid/ready, steps enabled slices through the shared unit one per cycle, and
//  reassembles the result word. Per-slice B/C enable masks model unconnected ports.
// PARAMETERS
//  SLICE_W     12   width of one slice of the shared datapath
//  NUM_SLICES  3    slices per word; WORD_W = SLICE_W*NUM_SLICES (36)
//  CNT_W       16   width of completed-operation counter
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand word valid
//  in_ready   out  1        controller can accept (IDLE only)
//  in_a       in   WORD_W   operand A
//  in_b       in   WORD_W   operand B
//  cfg_b_en   in   NUM_SLICES  per-slice B connected; 0 -> slice B driven 0
//  cfg_c_en   in   NUM_SLICES  per-slice C used; 0 -> slice skipped, result 0
//  slice_vld  out  1        slice_a/slice_b valid this cycle
//  slice_idx  out  2        slice index being processed
//  slice_a    out  SLICE_W  A slice to datapath
//  slice_b    out  SLICE_W  B slice to datapath
//  slice_c    in   SLICE_W  combinational datapath result, same cycle
//  out_valid  out  1        result word valid
//  out_ready  in   1        downstream accepts result
//  out_c      out  WORD_W   reassembled result
//  op_cnt     out  CNT_W    completed ops (out handshakes), wraps
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; slice_vld=0; slice_idx=0; slice_a/b=0; out_valid=0;
//   out_c=0; op_cnt=0; latched operands/masks cleared. Mid-op reset discards work.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. in_valid&&in_ready at edge T latches in_a,in_b,cfg_b_en,cfg_c_en;
//   idx <= lowest set bit of cfg_c_en. cfg_c_en==0 -> DONE at T+1 with out_c=0.
//   Otherwise RUN.
//  RUN: in_ready=0; slice_vld=1; slice_idx=idx; slice_a=A[idx*SLICE_W +: SLICE_W];
//   slice_b = cfg_b_en[idx] ? B slice : 0. At each edge, result[idx] <= slice_c.
//   idx <= next higher set bit of cfg_c_en; none left -> DONE. Ascending order only,
//   no bubbles. Disabled-C slices stay 0 in out_c.
//  Latency: out_valid asserts popcount(cfg_c_en)+1 cycles after accept (min 1, max 4).
//  DONE: out_valid=1, out_c stable, slice_vld=0. out_valid&&out_ready -> IDLE;
//   op_cnt+1 (wraps at 2^CNT_W). out_ready low: hold indefinitely.
//  No accept in DONE or RUN (in_ready=0). Earliest re-accept is the cycle after the
//   out handshake.
//  slice_c ignored when slice_vld=0. Input changes after accept have no effect.
// STRUCTURE
//  Package slice_seq_pkg: SLICE_W, NUM_SLICES, WORD_W constants; state_e enum
//   {IDLE,RUN,DONE}; slice_idx_t typedef.
//  Sub-module slice_next_pick: combinational next-set-bit finder (mask, current idx,
//   first flag -> next idx, none). Used for both initial and next index.
//  Result register WORD_W wide, per-slice write enable.
// TESTING
//  Full mask: c_en=3'b111,b_en=3'b111, A=36'h123_456_789 -> slice_idx 0,1,2 on
//   consecutive cycles; slice_a=h789,h456,h123; out_valid at T+4.
//  Sparse: c_en=3'b101 -> only idx 0,2 visited; out_c[23:12]=0; out_valid at T+3.
//  B masked: b_en=3'b011,c_en=3'b111,B=36'hFFF_FFF_FFF -> slice_b=0 on idx 2 only.
//  Empty: c_en=0 -> no slice_vld; out_valid at T+1, out_c=0; op_cnt increments.
//  Backpressure: out_ready=0 for 10 cycles -> out_c stable, in_ready=0; release ->
//   IDLE next cycle.
//  Reset: rst_n low during RUN idx 1 -> all outputs to reset values at once;
//   no out_valid; op_cnt=0.

Source files
------------

// File: rtl/slice_seq_pkg.sv
// Shared constants and types for the time-multiplexed slice controller.
package slice_seq_pkg;

  localparam int unsigned SLICE_W    = 12;
  localparam int unsigned NUM_SLICES = 3;
  localparam int unsigned WORD_W     = SLICE_W * NUM_SLICES;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] slice_idx_t;

endpackage

// File: rtl/slice_next_pick.sv
// Finds the next set bit of a slice mask strictly above the current index,
// or the lowest set bit when first is asserted.
module slice_next_pick #(
  parameter int unsigned NUM_SLICES = slice_seq_pkg::NUM_SLICES
) (
  input  logic [NUM_SLICES-1:0]     mask,
  input  slice_seq_pkg::slice_idx_t cur,
  input  logic                      first,
  output slice_seq_pkg::slice_idx_t nxt,
  output logic                      none
);
  import slice_seq_pkg::*;

  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (none && mask[i] && (first || i > 32'(cur))) begin
        nxt  = slice_idx_t'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/slice_seq_ctrl.sv
// Steps enabled slices of an operand word pair through one shared slice
// datapath, one slice per cycle, and reassembles the result word.
module slice_seq_ctrl #(
  parameter int unsigned SLICE_W    = slice_seq_pkg::SLICE_W,
  parameter int unsigned NUM_SLICES = slice_seq_pkg::NUM_SLICES,
  parameter int unsigned CNT_W      = slice_seq_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_a,
  input  logic [SLICE_W*NUM_SLICES-1:0] in_b,
  input  logic [NUM_SLICES-1:0]         cfg_b_en,
  input  logic [NUM_SLICES-1:0]         cfg_c_en,
  output logic                          slice_vld,
  output logic [1:0]                    slice_idx,
  output logic [SLICE_W-1:0]            slice_a,
  output logic [SLICE_W-1:0]            slice_b,
  input  logic [SLICE_W-1:0]            slice_c,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] out_c,
  output logic [CNT_W-1:0]              op_cnt
);
  localparam int unsigned WORD_W = SLICE_W * NUM_SLICES;
  import slice_seq_pkg::*;

  state_e                state;
  slice_idx_t            idx;
  slice_idx_t            pick_idx;
  logic                  pick_none;
  logic [WORD_W-1:0]     a_q;
  logic [WORD_W-1:0]     b_q;
  logic [WORD_W-1:0]     res_q;
  logic [NUM_SLICES-1:0] b_en_q;
  logic [NUM_SLICES-1:0] c_en_q;
  logic [NUM_SLICES-1:0] res_we;
  logic [CNT_W-1:0]      cnt_q;

  // One picker serves both the initial index (live mask in IDLE) and the
  // successor index (latched mask in RUN).
  slice_next_pick #(
    .NUM_SLICES(NUM_SLICES)
  ) u_pick (
    .mask  ((state == IDLE) ? cfg_c_en : c_en_q),
    .cur   (idx),
    .first (state == IDLE),
    .nxt   (pick_idx),
    .none  (pick_none)
  );

  always_comb begin
    res_we = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      res_we[i] = (state == RUN) && (idx == slice_idx_t'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      b_en_q <= '0;
      c_en_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLICES; i++) begin
        if (res_we[i]) res_q[i*SLICE_W +: SLICE_W] <= slice_c;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= in_a;
            b_q    <= in_b;
            b_en_q <= cfg_b_en;
            c_en_q <= cfg_c_en;
            res_q  <= '0;
            idx    <= pick_idx;
            state  <= pick_none ? DONE : RUN;
          end
        end
        RUN: begin
          if (pick_none) state <= DONE;
          else           idx   <= pick_idx;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    slice_vld = (state == RUN);
    out_valid = (state == DONE);
    slice_idx = slice_vld ? idx : '0;
    slice_a   = '0;
    slice_b   = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (slice_vld && idx == slice_idx_t'(i)) begin
        slice_a = a_q[i*SLICE_W +: SLICE_W];
        slice_b = b_en_q[i] ? b_q[i*SLICE_W +: SLICE_W] : '0;
      end
    end
    out_c  = res_q;
    op_cnt = cnt_q;
  end

endmodule

// File: tb/tb_slice_seq_ctrl.sv
// Self-checking bench for slice_seq_ctrl: directed vector table, randomized
// operations against a word-level reference model, backpressure and reset.
module tb_slice_seq_ctrl;

  localparam int unsigned SW = 12;
  localparam int unsigned NS = 3;
  localparam int unsigned WW = SW * NS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_a;
  logic [WW-1:0] in_b;
  logic [NS-1:0] cfg_b_en;
  logic [NS-1:0] cfg_c_en;
  logic          slice_vld;
  logic [1:0]    slice_idx;
  logic [SW-1:0] slice_a;
  logic [SW-1:0] slice_b;
  logic [SW-1:0] slice_c;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_c;
  logic [15:0]   op_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_cnt  = '0;

  slice_seq_ctrl #(
    .SLICE_W   (SW),
    .NUM_SLICES(NS),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cfg_b_en  (cfg_b_en),
    .cfg_c_en  (cfg_c_en),
    .slice_vld (slice_vld),
    .slice_idx (slice_idx),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_c   (slice_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in combinational slice cell: C = A + B + 1 (mod 2^12)
  assign slice_c = slice_a + slice_b + 12'd1;

  typedef struct {
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    logic [NS-1:0] b_en;
    logic [NS-1:0] c_en;
    int unsigned   hold;
    logic [WW-1:0] exp_c;
    int unsigned   exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] model_c(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                            input logic [NS-1:0] b_en, input logic [NS-1:0] c_en);
    logic [WW-1:0] r;
    logic [SW-1:0] bs;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      if (c_en[i]) begin
        bs = b_en[i] ? b[i*SW +: SW] : '0;
        r[i*SW +: SW] = a[i*SW +: SW] + bs + 12'd1;
      end
    end
    return r;
  endfunction

  function automatic int unsigned popcnt(input logic [NS-1:0] m);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NS; i++) n += int'(m[i]);
    return n;
  endfunction

  // Drives one operation starting at a negedge in IDLE and follows it through
  // every cycle up to and including the output handshake.
  task automatic run_op(input logic [WW-1:0] a, input logic [WW-1:0] b,
                        input logic [NS-1:0] b_en, input logic [NS-1:0] c_en,
                        input int unsigned hold, input logic [WW-1:0] exp_c,
                        input int unsigned exp_lat);
    int unsigned lat;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    in_valid = 1'b1; in_a = a; in_b = b; cfg_b_en = b_en; cfg_c_en = c_en;
    @(posedge clk); #1;
    // Post-accept input churn must not disturb the operation in flight
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    cfg_b_en = NS'($urandom); cfg_c_en = NS'($urandom); in_valid = 1'($urandom);
    @(negedge clk);
    lat = 1;
    for (int i = 0; i < NS; i++) begin
      if (c_en[i]) begin
        check("run_slice_vld", slice_vld, 1);
        check("run_slice_idx", slice_idx, i);
        check("run_slice_a", slice_a, a[i*SW +: SW]);
        check("run_slice_b", slice_b, b_en[i] ? b[i*SW +: SW] : 12'd0);
        check("run_out_valid", out_valid, 0);
        check("run_in_ready", in_ready, 0);
        @(negedge clk);
        lat++;
      end
    end
    check("latency", lat, exp_lat);
    check("done_out_valid", out_valid, 1);
    check("done_slice_vld", slice_vld, 0);
    check("done_in_ready", in_ready, 0);
    check("done_out_c", out_c, exp_c);
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_c", out_c, exp_c);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt++;
    @(negedge clk);
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_op_cnt", op_cnt, exp_cnt);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: 36'h123_456_789, b: 36'h001_002_003, b_en: 3'b111, c_en: 3'b111,
                hold: 0, exp_c: 36'h125_459_78D, exp_lat: 4};
    vecs[1] = '{a: 36'h123_456_789, b: 36'h001_002_003, b_en: 3'b111, c_en: 3'b101,
                hold: 1, exp_c: 36'h125_000_78D, exp_lat: 3};
    vecs[2] = '{a: 36'h123_456_789, b: 36'hFFF_FFF_FFF, b_en: 3'b011, c_en: 3'b111,
                hold: 0, exp_c: 36'h124_456_789, exp_lat: 4};
    vecs[3] = '{a: 36'hABC_DEF_012, b: 36'h111_111_111, b_en: 3'b000, c_en: 3'b000,
                hold: 2, exp_c: 36'h000_000_000, exp_lat: 1};
    vecs[4] = '{a: 36'hABC_DEF_012, b: 36'h111_111_111, b_en: 3'b000, c_en: 3'b010,
                hold: 0, exp_c: 36'h000_DF0_000, exp_lat: 2};
    vecs[5] = '{a: 36'hFFF_000_000, b: 36'h001_000_000, b_en: 3'b100, c_en: 3'b100,
                hold: 10, exp_c: 36'h001_000_000, exp_lat: 2};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    cfg_b_en = '0; cfg_c_en = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_slice_vld", slice_vld, 0);
    check("rst_slice_idx", slice_idx, 0);
    check("rst_slice_a", slice_a, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_c", out_c, 0);
    check("rst_op_cnt", op_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k])
      run_op(vecs[k].a, vecs[k].b, vecs[k].b_en, vecs[k].c_en,
             vecs[k].hold, vecs[k].exp_c, vecs[k].exp_lat);

    for (int r = 0; r < 40; r++) begin
      logic [WW-1:0] ra, rb;
      logic [NS-1:0] rbe, rce;
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rbe = NS'($urandom); rce = NS'($urandom);
      run_op(ra, rb, rbe, rce, $urandom_range(0, 3),
             model_c(ra, rb, rbe, rce), popcnt(rce) + 1);
    end

    // Reset in the middle of RUN, while slice 1 is on the datapath
    check("pre_reset_op_cnt_nonzero", op_cnt == 16'd0, 0);
    in_valid = 1'b1; in_a = 36'h123_456_789; in_b = 36'h001_002_003;
    cfg_b_en = 3'b111; cfg_c_en = 3'b111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_slice_idx", slice_idx, 1);
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_slice_vld", slice_vld, 0);
    check("mid_rst_slice_idx", slice_idx, 0);
    check("mid_rst_slice_a", slice_a, 0);
    check("mid_rst_slice_b", slice_b, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_c", out_c, 0);
    check("mid_rst_op_cnt", op_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("after_rst_out_valid", out_valid, 0);
      check("after_rst_slice_vld", slice_vld, 0);
    end
    run_op(36'h123_456_789, 36'h001_002_003, 3'b111, 3'b111, 0, 36'h125_459_78D, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
